// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory bus between the fetch stage (master) and
//               the 8K x 17-bit instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
    logic [15:0] addr;
    logic        rd_en;
    logic [16:0] instr;

    modport master (output addr, output rd_en, input instr);
    modport slave  (input addr, input rd_en, output instr);
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Owns the PC, drives the instruction
//               memory (read on the falling edge) and captures the returned
//               word into the IF/ID register. Handles stall, redirect, HLT
//               detection and out-of-range redirect faults.
//               Optional macro FETCH_PERF_CNT_EN adds saturating fetch_cnt and
//               stall_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          IM_DEPTH = 8192,
    parameter logic [3:0]  HLT_OPC  = 4'hF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          stall,
    input  wire logic          redirect,
    input  wire logic [15:0]   br_tgt,
    instr_fetch_if.master      mem,
    output logic      [16:0]   instr_ID,
    output logic      [15:0]   pc_ID,
    output logic               valid_ID,
    output logic               halted,
    output logic               fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic      [15:0]   fetch_cnt,
    output logic      [15:0]   stall_cnt
`endif
);

    localparam logic [0:0]  c_run     = 1'b0;
    localparam logic [0:0]  c_halt    = 1'b1;
    // 17-bit so that a 16-bit target can be compared against a depth of 65536
    localparam logic [16:0] c_depth   = 17'(IM_DEPTH);
    localparam logic [15:0] c_last_pc = 16'(IM_DEPTH - 1);

    logic [0:0]  r_state;
    logic [15:0] r_pc;
    logic [16:0] r_instr_id;
    logic [15:0] r_pc_id;
    logic        r_valid_id;
    logic        r_fault;

    logic        w_capture;
    logic        w_tgt_bad;
    logic        w_is_hlt;
    logic [15:0] w_pc_next;

    // A real capture happens only in RUN, unstalled and not squashed by redirect
    always_comb begin
        w_capture = (r_state == c_run) && !stall && !redirect;
        w_tgt_bad = ({1'b0, br_tgt} >= c_depth);
        w_is_hlt  = (mem.instr[15:12] == HLT_OPC);
        w_pc_next = (r_pc == c_last_pc) ? 16'h0000 : r_pc + 16'd1;
    end

    // Memory-side drive: rd_en depends combinationally on stall so a stalled
    // cycle leaves the memory output untouched
    always_comb begin
        mem.addr  = r_pc;
        mem.rd_en = !rst && (r_state == c_run) && !stall;
    end

    // PC, IF/ID register and RUN/HALT state; redirect outranks stall and HLT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_run;
            r_pc       <= RESET_PC;
            r_instr_id <= 17'h0;
            r_pc_id    <= 16'h0;
            r_valid_id <= 1'b0;
            r_fault    <= 1'b0;
        end else if (redirect) begin
            r_pc       <= br_tgt;
            r_valid_id <= 1'b0;
            if (w_tgt_bad) begin
                r_state <= c_halt;
                r_fault <= 1'b1;
            end else begin
                r_state <= c_run;
            end
        end else if (r_state == c_run) begin
            if (!stall) begin
                r_instr_id <= mem.instr;
                r_pc_id    <= r_pc;
                r_valid_id <= 1'b1;
                if (w_is_hlt) begin
                    // PC stays on the HLT so a later redirect is the only exit
                    r_state <= c_halt;
                end else begin
                    r_pc <= w_pc_next;
                end
            end
        end else begin
            r_valid_id <= 1'b0;
        end
    end

    assign instr_ID = r_instr_id;
    assign pc_ID    = r_pc_id;
    assign valid_ID = r_valid_id;
    assign halted   = (r_state == c_halt);
    assign fault    = r_fault;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating counters of valid captures and stalled RUN cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 16'h0;
            r_stall_cnt <= 16'h0;
        end else begin
            if (w_capture && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if ((r_state == c_run) && stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a falling-edge
//               instruction memory model and a table of per-cycle vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] br_tgt;
    logic [16:0] instr_ID;
    logic [15:0] pc_ID;
    logic        valid_ID;
    logic        halted;
    logic        fault;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (16'h0000),
        .IM_DEPTH (8192),
        .HLT_OPC  (4'hF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .redirect (redirect),
        .br_tgt   (br_tgt),
        .mem      (bus.master),
        .instr_ID (instr_ID),
        .pc_ID    (pc_ID),
        .valid_ID (valid_ID),
        .halted   (halted),
        .fault    (fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word i holds i+1, except a HLT at address 7
    logic [16:0] mem [0:8191];
    logic [16:0] mem_q;
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 17'(i + 1);
        mem[7] = 17'h0F000;
        mem_q  = 17'h0;
    end
    always @(negedge clk) begin
        if (bus.rd_en) mem_q <= (bus.addr < 16'd8192) ? mem[bus.addr[12:0]] : 17'h0;
    end
    assign bus.instr = mem_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] tgt;
        logic        e_rd_en;   // before the edge
        logic [15:0] e_addr;    // before the edge
        logic [16:0] e_instr;   // after the edge
        logic [15:0] e_pc_id;
        logic        e_valid;
        logic        e_halted;
        logic        e_fault;
    } vec_t;

    vec_t q[$];

    initial begin
        // stall redir tgt       rd_en addr       instr_ID  pc_ID     v  h  f
        q.push_back('{0, 0, 16'h0000, 1, 16'h0000, 17'h00001, 16'h0000, 1, 0, 0}); // reset release
        q.push_back('{0, 0, 16'h0000, 1, 16'h0001, 17'h00002, 16'h0001, 1, 0, 0});
        q.push_back('{0, 0, 16'h0000, 1, 16'h0002, 17'h00003, 16'h0002, 1, 0, 0});
        q.push_back('{0, 0, 16'h0000, 1, 16'h0003, 17'h00004, 16'h0003, 1, 0, 0});
        q.push_back('{0, 0, 16'h0000, 1, 16'h0004, 17'h00005, 16'h0004, 1, 0, 0});
        q.push_back('{1, 0, 16'h0000, 0, 16'h0005, 17'h00005, 16'h0004, 1, 0, 0}); // stall x3 at 5
        q.push_back('{1, 0, 16'h0000, 0, 16'h0005, 17'h00005, 16'h0004, 1, 0, 0});
        q.push_back('{1, 0, 16'h0000, 0, 16'h0005, 17'h00005, 16'h0004, 1, 0, 0});
        q.push_back('{0, 0, 16'h0000, 1, 16'h0005, 17'h00006, 16'h0005, 1, 0, 0}); // resume at 5
        q.push_back('{0, 0, 16'h0000, 1, 16'h0006, 17'h00007, 16'h0006, 1, 0, 0});
        q.push_back('{0, 0, 16'h0000, 1, 16'h0007, 17'h0F000, 16'h0007, 1, 1, 0}); // HLT delivered
        q.push_back('{0, 0, 16'h0000, 0, 16'h0007, 17'h0F000, 16'h0007, 0, 1, 0});
        q.push_back('{1, 0, 16'h0000, 0, 16'h0007, 17'h0F000, 16'h0007, 0, 1, 0}); // stall ignored
        q.push_back('{0, 1, 16'h0000, 0, 16'h0007, 17'h0F000, 16'h0007, 0, 0, 0}); // exit HALT
        q.push_back('{0, 0, 16'h0000, 1, 16'h0000, 17'h00001, 16'h0000, 1, 0, 0});
        q.push_back('{1, 1, 16'h0100, 0, 16'h0001, 17'h00001, 16'h0000, 0, 0, 0}); // redirect+stall
        q.push_back('{0, 0, 16'h0000, 1, 16'h0100, 17'h00101, 16'h0100, 1, 0, 0});
        q.push_back('{0, 1, 16'h2000, 1, 16'h0101, 17'h00101, 16'h0100, 0, 1, 1}); // fault
        q.push_back('{0, 0, 16'h0000, 0, 16'h2000, 17'h00101, 16'h0100, 0, 1, 1});
        q.push_back('{0, 1, 16'h0000, 0, 16'h2000, 17'h00101, 16'h0100, 0, 0, 1}); // restart, fault sticky
        q.push_back('{0, 0, 16'h0000, 1, 16'h0000, 17'h00001, 16'h0000, 1, 0, 1});
        q.push_back('{0, 1, 16'h1FFE, 1, 16'h0001, 17'h00001, 16'h0000, 0, 0, 1});
        q.push_back('{0, 0, 16'h0000, 1, 16'h1FFE, 17'h01FFF, 16'h1FFE, 1, 0, 1});
        q.push_back('{0, 0, 16'h0000, 1, 16'h1FFF, 17'h02000, 16'h1FFF, 1, 0, 1}); // last address
        q.push_back('{0, 0, 16'h0000, 1, 16'h0000, 17'h00001, 16'h0000, 1, 0, 1}); // wrapped
    end

    // Hard time limit so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; br_tgt = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_en",    32'(bus.rd_en), 32'h0);
        chk("reset addr",     32'(bus.addr),  32'h0);
        chk("reset instr_ID", 32'(instr_ID),  32'h0);
        chk("reset pc_ID",    32'(pc_ID),     32'h0);
        chk("reset valid_ID", 32'(valid_ID),  32'h0);
        chk("reset halted",   32'(halted),    32'h0);
        chk("reset fault",    32'(fault),     32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("reset fetch_cnt", 32'(fetch_cnt), 32'h0);
        chk("reset stall_cnt", 32'(stall_cnt), 32'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < q.size(); i++) begin
            stall = q[i].stall; redirect = q[i].redir; br_tgt = q[i].tgt;
            @(negedge clk); #1;
            chk($sformatf("v%0d rd_en", i),    32'(bus.rd_en), 32'(q[i].e_rd_en));
            chk($sformatf("v%0d addr", i),     32'(bus.addr),  32'(q[i].e_addr));
            @(posedge clk); #1;
            chk($sformatf("v%0d instr_ID", i), 32'(instr_ID),  32'(q[i].e_instr));
            chk($sformatf("v%0d pc_ID", i),    32'(pc_ID),     32'(q[i].e_pc_id));
            chk($sformatf("v%0d valid_ID", i), 32'(valid_ID),  32'(q[i].e_valid));
            chk($sformatf("v%0d halted", i),   32'(halted),    32'(q[i].e_halted));
            chk($sformatf("v%0d fault", i),    32'(fault),     32'(q[i].e_fault));
        end
        stall = 1'b0; redirect = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        // 14 valid captures and 4 stalled RUN cycles in the table above
        chk("table fetch_cnt", 32'(fetch_cnt), 32'd14);
        chk("table stall_cnt", 32'(stall_cnt), 32'd4);
`endif

        // Reset mid-stream overrides a simultaneous redirect and clears fault
        rst = 1'b1; redirect = 1'b1; br_tgt = 16'h0055;
        @(negedge clk); #1;
        chk("rst rd_en", 32'(bus.rd_en), 32'h0);
        @(posedge clk); #1;
        chk("rst addr",     32'(bus.addr), 32'h0);
        chk("rst fault",    32'(fault),    32'h0);
        chk("rst halted",   32'(halted),   32'h0);
        chk("rst valid_ID", 32'(valid_ID), 32'h0);
        chk("rst instr_ID", 32'(instr_ID), 32'h0);
        rst = 1'b0; redirect = 1'b0;
        @(posedge clk); #1;
        chk("post-rst instr_ID", 32'(instr_ID), 32'h1);
        chk("post-rst pc_ID",    32'(pc_ID),    32'h0);
        chk("post-rst valid_ID", 32'(valid_ID), 32'h1);

        // Reset also overrides an HLT capture on the same edge
        br_tgt = 16'h0007; redirect = 1'b1;
        @(posedge clk); #1;
        redirect = 1'b0; rst = 1'b1;     // next edge would capture the HLT at 7
        @(posedge clk); #1;
        chk("rst-over-hlt halted", 32'(halted),   32'h0);
        chk("rst-over-hlt valid",  32'(valid_ID), 32'h0);
        chk("rst-over-hlt addr",   32'(bus.addr), 32'h0);
        rst = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        // Free-run past 65535 captures; remove the HLT so fetch never stops
        mem[7] = 17'h00008;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat fetch_cnt", 32'(fetch_cnt), 32'hFFFF);
        @(posedge clk); #1;
        chk("sat fetch_cnt hold", 32'(fetch_cnt), 32'hFFFF);
        chk("sat stall_cnt", 32'(stall_cnt), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
